// File: rtl/id_ex_exec.sv
// ID/EX pipeline register and EX stage: single-cycle logic/shift ops plus an
// iterative shift-add multiplier that stalls the pipeline while it runs.
module id_ex_exec #(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic [7:0]  id_aluop_i,
  input  logic [2:0]  id_alusel_i,
  input  logic [31:0] id_reg1_i,
  input  logic [31:0] id_reg2_i,
  input  logic [4:0]  id_wd_i,
  input  logic        id_wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [7:0] EXE_MUL_OP = 8'b1010_1001;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MUL   = 3'b101;

  localparam int CNT_W = $clog2(MUL_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  logic [7:0]  ex_aluop_q,  ex_aluop_d;
  logic [2:0]  ex_alusel_q, ex_alusel_d;
  logic [31:0] ex_reg1_q,   ex_reg1_d;
  logic [31:0] ex_reg2_q,   ex_reg2_d;
  logic [4:0]  ex_wd_q,     ex_wd_d;
  logic        ex_wreg_q,   ex_wreg_d;

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      acc_q,   acc_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplr_q,  mplr_d;

  logic        idex_load;
  logic        mul_pending;
  logic [31:0] logic_res;
  logic [31:0] shift_res;

  // The register changes unless both ID and EX are stalled.
  assign idex_load = !(stall_i[2] && stall_i[3]);

  always_comb begin
    ex_aluop_d  = ex_aluop_q;
    ex_alusel_d = ex_alusel_q;
    ex_reg1_d   = ex_reg1_q;
    ex_reg2_d   = ex_reg2_q;
    ex_wd_d     = ex_wd_q;
    ex_wreg_d   = ex_wreg_q;
    if (!stall_i[2]) begin
      ex_aluop_d  = id_aluop_i;
      ex_alusel_d = id_alusel_i;
      ex_reg1_d   = id_reg1_i;
      ex_reg2_d   = id_reg2_i;
      ex_wd_d     = id_wd_i;
      ex_wreg_d   = id_wreg_i;
    end else if (!stall_i[3]) begin
      ex_aluop_d  = EXE_NOP_OP;
      ex_alusel_d = EXE_RES_NOP;
      ex_reg1_d   = 32'h0;
      ex_reg2_d   = 32'h0;
      ex_wd_d     = 5'd0;
      ex_wreg_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_aluop_q  <= EXE_NOP_OP;
      ex_alusel_q <= EXE_RES_NOP;
      ex_reg1_q   <= 32'h0;
      ex_reg2_q   <= 32'h0;
      ex_wd_q     <= 5'd0;
      ex_wreg_q   <= 1'b0;
    end else begin
      ex_aluop_q  <= ex_aluop_d;
      ex_alusel_q <= ex_alusel_d;
      ex_reg1_q   <= ex_reg1_d;
      ex_reg2_q   <= ex_reg2_d;
      ex_wd_q     <= ex_wd_d;
      ex_wreg_q   <= ex_wreg_d;
    end
  end

  // Any ID/EX load returns the multiplier to IDLE; IDLE only starts when the
  // register is held, so the latched operands always match the instruction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    case (state_q)
      MUL_IDLE: begin
        if (ex_aluop_q == EXE_MUL_OP && !idex_load) begin
          mcand_d = ex_reg1_q;
          mplr_d  = ex_reg2_q;
          acc_d   = 32'h0;
          cnt_d   = '0;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (idex_load) begin
          state_d = MUL_IDLE;
        end else begin
          if (mplr_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (idex_load) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      acc_q   <= 32'h0;
      mcand_q <= 32'h0;
      mplr_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  assign mul_pending = (ex_aluop_q == EXE_MUL_OP) && (state_q != MUL_DONE);

  always_comb begin
    logic_res = 32'h0;
    case (ex_aluop_q)
      EXE_OR_OP:  logic_res = ex_reg1_q | ex_reg2_q;
      EXE_AND_OP: logic_res = ex_reg1_q & ex_reg2_q;
      EXE_XOR_OP: logic_res = ex_reg1_q ^ ex_reg2_q;
      EXE_NOR_OP: logic_res = ~(ex_reg1_q | ex_reg2_q);
      default:    logic_res = 32'h0;
    endcase
  end

  always_comb begin
    shift_res = 32'h0;
    case (ex_aluop_q)
      EXE_SLL_OP: shift_res = ex_reg2_q << ex_reg1_q[4:0];
      EXE_SRL_OP: shift_res = ex_reg2_q >> ex_reg1_q[4:0];
      EXE_SRA_OP: shift_res = 32'($signed(ex_reg2_q) >>> ex_reg1_q[4:0]);
      default:    shift_res = 32'h0;
    endcase
  end

  always_comb begin
    wdata_o = 32'h0;
    case (ex_alusel_q)
      EXE_RES_LOGIC: wdata_o = logic_res;
      EXE_RES_SHIFT: wdata_o = shift_res;
      EXE_RES_MUL:   wdata_o = mul_pending ? 32'h0 : acc_q;
      default:       wdata_o = 32'h0;
    endcase
  end

  assign wd_o       = ex_wd_q;
  assign wreg_o     = ex_wreg_q && !mul_pending;
  assign stallreq_o = mul_pending;

endmodule

// File: tb/tb_id_ex_exec.sv
// Scoreboard bench for id_ex_exec: expected results are queued when an
// instruction is driven and compared when the EX stage presents it.
module tb_id_ex_exec;

  localparam logic [7:0] OP_NOP = 8'b0000_0000;
  localparam logic [7:0] OP_AND = 8'b0010_0100;
  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_XOR = 8'b0010_0110;
  localparam logic [7:0] OP_NOR = 8'b0010_0111;
  localparam logic [7:0] OP_SLL = 8'b0111_1100;
  localparam logic [7:0] OP_SRL = 8'b0000_0010;
  localparam logic [7:0] OP_SRA = 8'b0000_0011;
  localparam logic [7:0] OP_MUL = 8'b1010_1001;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MUL   = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic [7:0]  id_aluop_i;
  logic [2:0]  id_alusel_i;
  logic [31:0] id_reg1_i;
  logic [31:0] id_reg2_i;
  logic [4:0]  id_wd_i;
  logic        id_wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  id_ex_exec dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .id_aluop_i (id_aluop_i),
    .id_alusel_i(id_alusel_i),
    .id_reg1_i  (id_reg1_i),
    .id_reg2_i  (id_reg2_i),
    .id_wd_i    (id_wd_i),
    .id_wreg_i  (id_wreg_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_OR)  r = a | b;
      if (op == OP_AND) r = a & b;
      if (op == OP_XOR) r = a ^ b;
      if (op == OP_NOR) r = ~(a | b);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) r = b << a[4:0];
      if (op == OP_SRL) r = b >> a[4:0];
      if (op == OP_SRA)
        for (int i = 0; i < 32; i++) r[i] = (i + a[4:0] > 31) ? b[31] : b[i + a[4:0]];
    end else if (sel == SEL_MUL) begin
      r = a * b;
    end
    return r;
  endfunction

  // Called at a negedge; drives one instruction and advances to the next negedge.
  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg,
                       input logic [5:0] stall);
    exp_t e;
    id_aluop_i  = op;
    id_alusel_i = sel;
    id_reg1_i   = a;
    id_reg2_i   = b;
    id_wd_i     = wd;
    id_wreg_i   = wreg;
    stall_i     = stall;
    if (stall[2]) begin
      e.wd = 5'd0; e.wreg = 1'b0; e.wdata = 32'h0;
    end else begin
      e.wd = wd; e.wreg = wreg; e.wdata = model(op, sel, a, b);
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_sb"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_wdata"}, wdata_o, e.wdata);
    chk({tag, "_wreg"}, {31'h0, wreg_o}, {31'h0, e.wreg});
    chk({tag, "_wd"}, {27'h0, wd_o}, {27'h0, e.wd});
    chk({tag, "_stallreq"}, {31'h0, stallreq_o}, 32'h0);
  endtask

  // Acts as ctrl while the multiplier requests a stall, then checks the result.
  task automatic run_mul(input string tag);
    int cycles = 0;
    int wreg_hi = 0;
    while (stallreq_o && cycles < 100) begin
      cycles++;
      if (wreg_o) wreg_hi++;
      stall_i = 6'b001111;
      @(posedge clk);
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, cycles, 33);
    chk({tag, "_wreg_low"}, wreg_hi, 0);
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 6'b0;
    id_aluop_i = OP_OR; id_alusel_i = SEL_LOGIC;
    id_reg1_i = 32'h1234_5678; id_reg2_i = 32'h9ABC_DEF0;
    id_wd_i = 5'd9; id_wreg_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
    chk("rst_wd", {27'h0, wd_o}, 32'h0);
    chk("rst_stallreq", {31'h0, stallreq_o}, 32'h0);
    rst = 1'b0;

    drive(OP_OR, SEL_LOGIC, 32'h0000_F0F0, 32'h00FF_0000, 5'd5, 1'b1, 6'b0);
    chk("or_literal", wdata_o, 32'h00FF_F0F0);
    check_out("or");
    drive(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0010, 5'd6, 1'b1, 6'b0);
    chk("sra_literal", wdata_o, 32'hF800_0001);
    check_out("sra");
    drive(OP_SLL, SEL_SHIFT, 32'd31, 32'h1, 5'd7, 1'b1, 6'b0);
    chk("sll_literal", wdata_o, 32'h8000_0000);
    check_out("sll");
    drive(OP_SRL, SEL_SHIFT, 32'd8, 32'h8000_0010, 5'd8, 1'b1, 6'b0);
    check_out("srl");
    drive(OP_AND, SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd10, 1'b0, 6'b0);
    check_out("and");
    drive(OP_NOR, SEL_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 5'd11, 1'b1, 6'b0);
    check_out("nor");
    drive(OP_XOR, 3'b111, 32'hAAAA_AAAA, 32'h5555_5555, 5'd12, 1'b1, 6'b0);
    check_out("bad_sel");
    for (int i = 0; i < 6; i++) begin
      logic [7:0] op;
      logic [2:0] sel;
      op  = (i % 3 == 0) ? OP_XOR : (i % 3 == 1) ? OP_SRA : OP_SRL;
      sel = (i % 3 == 0) ? SEL_LOGIC : SEL_SHIFT;
      drive(op, sel, $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1, 6'b0);
      check_out("rand");
    end

    drive(OP_MUL, SEL_MUL, 32'hFFFF_FFFD, 32'd7, 5'd3, 1'b1, 6'b0);
    run_mul("mul_neg");
    chk("mul_literal", wdata_o, 32'hFFFF_FFEB);

    stall_i = 6'b011111;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_wdata", wdata_o, 32'hFFFF_FFEB);
      chk("hold_wreg", {31'h0, wreg_o}, 32'h1);
      chk("hold_stallreq", {31'h0, stallreq_o}, 32'h0);
    end

    drive(OP_MUL, SEL_MUL, 32'h0, 32'hFFFF_FFFF, 5'd4, 1'b1, 6'b0);
    chk("reload_detect", {31'h0, stallreq_o}, 32'h1);
    run_mul("mul_zero");

    drive(OP_OR, SEL_LOGIC, 32'h1, 32'h2, 5'd13, 1'b1, 6'b0);
    check_out("pre_bubble");
    drive(OP_XOR, SEL_LOGIC, 32'hFFFF_0000, 32'h1234_5678, 5'd14, 1'b1, 6'b000111);
    check_out("bubble");

    drive(OP_MUL, SEL_MUL, 32'h0001_2345, 32'h0000_6789, 5'd15, 1'b1, 6'b0);
    stall_i = 6'b001111;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midbusy_stallreq", {31'h0, stallreq_o}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    chk("rstbusy_wdata", wdata_o, 32'h0);
    chk("rstbusy_wreg", {31'h0, wreg_o}, 32'h0);
    chk("rstbusy_wd", {27'h0, wd_o}, 32'h0);
    chk("rstbusy_stallreq", {31'h0, stallreq_o}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("after_rst_stallreq", {31'h0, stallreq_o}, 32'h0);

    drive(OP_MUL, SEL_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 1'b1, 6'b0);
    run_mul("b2b_1");
    drive(OP_MUL, SEL_MUL, 32'h8000_0001, 32'h8000_0001, 5'd21, 1'b1, 6'b0);
    run_mul("b2b_2");
    drive(OP_MUL, SEL_MUL, $urandom, $urandom, 5'd22, 1'b1, 6'b0);
    run_mul("b2b_3");

    drive(OP_AND, SEL_LOGIC, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd23, 1'b1, 6'b0);
    check_out("post_mul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
